// File: rtl/pciecfg_ctrl.sv
// ============================================================================
// Module   : pciecfg_ctrl
// Purpose  : Pops PCIe config requests from a FIFO, runs one cfg_mgmt access
//            at a time with a timeout, and returns a tagged UDP response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pciecfg_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
    parameter logic [15:0] UDP_PORT       = 16'h5001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [64:0] fifo_dout,
    output logic [9:0]  cfg_mgmt_dwaddr,
    output logic [3:0]  cfg_mgmt_byte_en,
    output logic [31:0] cfg_mgmt_di,
    output logic        cfg_mgmt_wr_en,
    output logic        cfg_mgmt_rd_en,
    output logic        cfg_mgmt_wr_readonly,
    input  logic [31:0] cfg_mgmt_do,
    input  logic        cfg_mgmt_rd_wr_done,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [47:0] resp_pkt,
    output logic [15:0] resp_udp_check,
    output logic [15:0] resp_udp_port,
    output logic        resp_err,
    output logic [15:0] stat_req_cnt,
    output logic [15:0] stat_err_cnt
);

    localparam logic [1:0]  c_OP_RD    = 2'b00;
    localparam logic [1:0]  c_OP_WR    = 2'b01;
    localparam logic [31:0] c_ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_armed;
    logic [1:0]  r_opcode;
    logic [3:0]  r_byte_mask;
    logic [9:0]  r_dwaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_byte_en;
    logic [15:0] r_udp_check;
    logic [31:0] r_resp_data;
    logic        r_err;
    logic [15:0] r_tmo;
    logic [15:0] r_req_cnt;
    logic [15:0] r_err_cnt;

    logic        w_dv;
    logic [15:0] w_udp;
    logic [1:0]  w_op;
    logic [3:0]  w_mask;
    logic [9:0]  w_addr;
    logic [31:0] w_data;
    logic        w_op_ok;
    logic        w_tmo_hit;

    assign w_dv      = fifo_dout[64];
    assign w_udp     = fifo_dout[63:48];
    assign w_op      = fifo_dout[47:46];
    assign w_mask    = fifo_dout[45:42];
    assign w_addr    = fifo_dout[41:32];
    assign w_data    = fifo_dout[31:0];
    assign w_op_ok   = (w_op == c_OP_RD) || (w_op == c_OP_WR);
    assign w_tmo_hit = (r_tmo == TIMEOUT_CYCLES - 16'd1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        fifo_rd_en     = 1'b0;
        cfg_mgmt_rd_en = 1'b0;
        cfg_mgmt_wr_en = 1'b0;
        resp_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_armed holds off the first pop until one edge after reset release
                if (r_armed && !fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    w_next     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!w_dv) begin
                    w_next = ST_IDLE;
                end else if (w_op_ok) begin
                    w_next = ST_ACCESS;
                end else begin
                    w_next = ST_RESP;
                end
            end
            ST_ACCESS: begin
                cfg_mgmt_rd_en = (r_opcode == c_OP_RD);
                cfg_mgmt_wr_en = (r_opcode == c_OP_WR);
                if (cfg_mgmt_rd_wr_done || w_tmo_hit) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed     <= 1'b0;
            r_opcode    <= '0;
            r_byte_mask <= '0;
            r_dwaddr    <= '0;
            r_wdata     <= '0;
            r_byte_en   <= '0;
            r_udp_check <= '0;
            r_resp_data <= '0;
            r_err       <= 1'b0;
            r_tmo       <= '0;
            r_req_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_armed <= 1'b1;
            if (r_state == ST_LOAD && w_dv) begin
                r_opcode    <= w_op;
                r_byte_mask <= w_mask;
                r_dwaddr    <= w_addr;
                r_wdata     <= w_data;
                r_byte_en   <= (w_op == c_OP_WR) ? w_mask : 4'h0;
                r_udp_check <= w_udp;
                r_tmo       <= '0;
                r_req_cnt   <= sat_inc(r_req_cnt);
                if (w_op_ok) begin
                    r_err <= 1'b0;
                end else begin
                    r_resp_data <= c_ERR_DATA;
                    r_err       <= 1'b1;
                    r_err_cnt   <= sat_inc(r_err_cnt);
                end
            end
            if (r_state == ST_ACCESS) begin
                r_tmo <= r_tmo + 16'd1;
                // A completion on the final timeout cycle still counts as success
                if (cfg_mgmt_rd_wr_done) begin
                    r_resp_data <= (r_opcode == c_OP_RD) ? cfg_mgmt_do : r_wdata;
                    r_err       <= 1'b0;
                end else if (w_tmo_hit) begin
                    r_resp_data <= c_ERR_DATA;
                    r_err       <= 1'b1;
                    r_err_cnt   <= sat_inc(r_err_cnt);
                end
            end
        end
    end

    assign cfg_mgmt_dwaddr      = r_dwaddr;
    assign cfg_mgmt_byte_en     = r_byte_en;
    assign cfg_mgmt_di          = r_wdata;
    assign cfg_mgmt_wr_readonly = 1'b0;
    assign resp_pkt             = {r_opcode, r_byte_mask, r_dwaddr, r_resp_data};
    assign resp_udp_check       = r_udp_check;
    assign resp_udp_port        = UDP_PORT;
    assign resp_err             = r_err;
    assign stat_req_cnt         = r_req_cnt;
    assign stat_err_cnt         = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pciecfg_ctrl.sv
// ============================================================================
// Module   : tb_pciecfg_ctrl
// Purpose  : Directed self-checking bench for pciecfg_ctrl with a FIFO model
//            and a latency-programmable cfg_mgmt responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pciecfg_ctrl;

    localparam logic [1:0] c_RD = 2'b00;
    localparam logic [1:0] c_WR = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [64:0] fifo_dout;
    logic [9:0]  cfg_mgmt_dwaddr;
    logic [3:0]  cfg_mgmt_byte_en;
    logic [31:0] cfg_mgmt_di;
    logic        cfg_mgmt_wr_en;
    logic        cfg_mgmt_rd_en;
    logic        cfg_mgmt_wr_readonly;
    logic [31:0] cfg_mgmt_do;
    logic        cfg_mgmt_rd_wr_done;
    logic        resp_valid;
    logic        resp_ready;
    logic [47:0] resp_pkt;
    logic [15:0] resp_udp_check;
    logic [15:0] resp_udp_port;
    logic        resp_err;
    logic [15:0] stat_req_cnt;
    logic [15:0] stat_err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // FIFO model: entries written by the stimulus, popped on fifo_rd_en
    logic [64:0] mem [0:31];
    int          n_push = 0;
    int          n_pop  = 0;

    // Responder state
    int          lat = 0;
    int          acc_cyc = 0;
    int          rd_hi = 0;
    int          wr_hi = 0;
    logic [3:0]  last_be = '0;
    logic [31:0] last_di = '0;

    pciecfg_ctrl #(
        .TIMEOUT_CYCLES (16'd8),
        .UDP_PORT       (16'h5001)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .fifo_empty           (fifo_empty),
        .fifo_rd_en           (fifo_rd_en),
        .fifo_dout            (fifo_dout),
        .cfg_mgmt_dwaddr      (cfg_mgmt_dwaddr),
        .cfg_mgmt_byte_en     (cfg_mgmt_byte_en),
        .cfg_mgmt_di          (cfg_mgmt_di),
        .cfg_mgmt_wr_en       (cfg_mgmt_wr_en),
        .cfg_mgmt_rd_en       (cfg_mgmt_rd_en),
        .cfg_mgmt_wr_readonly (cfg_mgmt_wr_readonly),
        .cfg_mgmt_do          (cfg_mgmt_do),
        .cfg_mgmt_rd_wr_done  (cfg_mgmt_rd_wr_done),
        .resp_valid           (resp_valid),
        .resp_ready           (resp_ready),
        .resp_pkt             (resp_pkt),
        .resp_udp_check       (resp_udp_check),
        .resp_udp_port        (resp_udp_port),
        .resp_err             (resp_err),
        .stat_req_cnt         (stat_req_cnt),
        .stat_err_cnt         (stat_err_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (n_push == n_pop);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[n_pop];
            n_pop     <= n_pop + 1;
        end
    end

    // Done pulses in the lat-th strobe cycle; lat = 0 never answers
    always @(negedge clk) begin
        if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) begin
            acc_cyc = acc_cyc + 1;
            if (cfg_mgmt_rd_en) rd_hi = rd_hi + 1;
            if (cfg_mgmt_wr_en) begin
                wr_hi   = wr_hi + 1;
                last_be = cfg_mgmt_byte_en;
                last_di = cfg_mgmt_di;
            end
            cfg_mgmt_rd_wr_done = (acc_cyc == lat);
        end else begin
            acc_cyc             = 0;
            cfg_mgmt_rd_wr_done = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] ent(input logic dv, input logic [15:0] udp, input logic [1:0] op,
                                        input logic [3:0] m, input logic [9:0] a, input logic [31:0] d);
        return {dv, udp, op, m, a, d};
    endfunction

    task automatic push(input logic [64:0] e);
        mem[n_push] = e;
        n_push      = n_push + 1;
    endtask

    task automatic get_resp(input int hold, output logic [47:0] pkt, output logic [15:0] udp,
                            output logic err);
        int   t = 0;
        bit   stable = 1'b1;
        int   pops0;
        while (!resp_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("resp_seen", {63'd0, resp_valid}, 64'd1);
        pkt = resp_pkt;
        udp = resp_udp_check;
        err = resp_err;
        if (!resp_valid) return;
        pops0 = n_pop;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_pkt !== pkt || resp_udp_check !== udp || resp_err !== err)
                stable = 1'b0;
        end
        if (hold > 0) begin
            chk("hold_stable", {63'd0, stable}, 64'd1);
            chk("hold_no_pop", n_pop, pops0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] pkt;
        logic [15:0] udp;
        logic        err;
        int          rd0, wr0;
        bit          seen;

        rst_n       = 1'b0;
        resp_ready  = 1'b0;
        cfg_mgmt_do = '0;
        repeat (3) @(negedge clk);

        // Reset state, with a request already waiting in the FIFO
        lat         = 3;
        cfg_mgmt_do = 32'hF000_000C;
        push(ent(1'b1, 16'hABCD, c_RD, 4'hF, 10'h004, 32'h0));
        @(negedge clk);
        chk("rst_fifo_rd_en", fifo_rd_en, 0);
        chk("rst_rd_en", cfg_mgmt_rd_en, 0);
        chk("rst_wr_en", cfg_mgmt_wr_en, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_pkt", resp_pkt, 0);
        chk("rst_cfg_regs", {cfg_mgmt_dwaddr, cfg_mgmt_byte_en, cfg_mgmt_di}, 0);
        chk("rst_stats", {stat_req_cnt, stat_err_cnt}, 0);
        chk("wr_readonly", cfg_mgmt_wr_readonly, 0);
        chk("udp_port", resp_udp_port, 16'h5001);

        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("no_pop_first_edge", n_pop, 0);
        @(negedge clk);

        // Read with done in the third strobe cycle
        get_resp(0, pkt, udp, err);
        chk("rd_pkt", pkt, {c_RD, 4'hF, 10'h004, 32'hF000_000C});
        chk("rd_udp", udp, 16'hABCD);
        chk("rd_err", err, 0);
        chk("rd_strobe_cycles", rd_hi, 3);
        chk("rd_no_wr", wr_hi, 0);

        // Write, immediate done
        lat = 1;
        push(ent(1'b1, 16'h1234, c_WR, 4'h3, 10'h001, 32'h0000_0006));
        get_resp(0, pkt, udp, err);
        chk("wr_pkt", pkt, {c_WR, 4'h3, 10'h001, 32'h0000_0006});
        chk("wr_udp", udp, 16'h1234);
        chk("wr_err", err, 0);
        chk("wr_byte_en", last_be, 4'h3);
        chk("wr_di", last_di, 32'h6);
        chk("wr_strobe_cycles", wr_hi, 1);

        // Timeout after 8 strobe cycles
        rd0 = rd_hi;
        lat = 0;
        push(ent(1'b1, 16'h0BEE, c_RD, 4'hF, 10'h010, 32'h0));
        get_resp(0, pkt, udp, err);
        chk("tmo_pkt", pkt, {c_RD, 4'hF, 10'h010, 32'hFFFF_FFFF});
        chk("tmo_err", err, 1);
        chk("tmo_strobe_cycles", rd_hi - rd0, 8);
        chk("tmo_stats", {stat_req_cnt, stat_err_cnt}, {16'd3, 16'd1});

        // Done on the timeout cycle wins
        rd0         = rd_hi;
        lat         = 8;
        cfg_mgmt_do = 32'hCAFE_F00D;
        push(ent(1'b1, 16'h7777, c_RD, 4'h1, 10'h020, 32'h0));
        get_resp(0, pkt, udp, err);
        chk("edge_pkt", pkt, {c_RD, 4'h1, 10'h020, 32'hCAFE_F00D});
        chk("edge_err", err, 0);
        chk("edge_strobe_cycles", rd_hi - rd0, 8);
        chk("edge_stats", {stat_req_cnt, stat_err_cnt}, {16'd4, 16'd1});

        // Bad opcode: error response, no access
        rd0 = rd_hi;
        wr0 = wr_hi;
        push(ent(1'b1, 16'h5555, 2'b11, 4'hA, 10'h3FF, 32'h1234_5678));
        get_resp(0, pkt, udp, err);
        chk("badop_pkt", pkt, {2'b11, 4'hA, 10'h3FF, 32'hFFFF_FFFF});
        chk("badop_udp", udp, 16'h5555);
        chk("badop_err", err, 1);
        chk("badop_no_strobe", (rd_hi - rd0) + (wr_hi - wr0), 0);
        chk("badop_stats", {stat_req_cnt, stat_err_cnt}, {16'd5, 16'd2});

        // data_valid = 0 is popped and dropped silently
        rd0  = rd_hi;
        seen = 1'b0;
        push(ent(1'b0, 16'h9999, c_RD, 4'hF, 10'h011, 32'h0));
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("dv0_no_resp", {63'd0, seen}, 0);
        chk("dv0_popped", n_pop, n_push);
        chk("dv0_no_strobe", rd_hi - rd0, 0);
        chk("dv0_stats", {stat_req_cnt, stat_err_cnt}, {16'd5, 16'd2});

        // Backpressure with a second request queued behind
        lat         = 1;
        cfg_mgmt_do = 32'h1111_2222;
        push(ent(1'b1, 16'hAAAA, c_RD, 4'hF, 10'h005, 32'h0));
        push(ent(1'b1, 16'hBBBB, c_WR, 4'hC, 10'h006, 32'hDEAD_BEEF));
        get_resp(10, pkt, udp, err);
        chk("bp_pkt1", pkt, {c_RD, 4'hF, 10'h005, 32'h1111_2222});
        chk("bp_udp1", udp, 16'hAAAA);
        get_resp(0, pkt, udp, err);
        chk("bp_pkt2", pkt, {c_WR, 4'hC, 10'h006, 32'hDEAD_BEEF});
        chk("bp_udp2", udp, 16'hBBBB);
        chk("bp_wr_be", last_be, 4'hC);
        chk("bp_stats", {stat_req_cnt, stat_err_cnt}, {16'd7, 16'd2});

        // Reset in the middle of a write access
        lat  = 0;
        seen = 1'b0;
        push(ent(1'b1, 16'hCCCC, c_WR, 4'hF, 10'h007, 32'h55));
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (cfg_mgmt_wr_en) seen = 1'b1;
        end
        chk("mid_wr_seen", {63'd0, seen}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", cfg_mgmt_wr_en, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_stats", {stat_req_cnt, stat_err_cnt}, 0);
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        lat         = 2;
        cfg_mgmt_do = 32'h0000_BEEF;
        push(ent(1'b1, 16'hDDDD, c_RD, 4'hF, 10'h008, 32'h0));
        get_resp(0, pkt, udp, err);
        chk("post_rst_pkt", pkt, {c_RD, 4'hF, 10'h008, 32'h0000_BEEF});
        chk("post_rst_err", err, 0);
        chk("post_rst_stats", {stat_req_cnt, stat_err_cnt}, {16'd1, 16'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
